// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection phase scheduler.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_GREEN     = 3'd0,
      NS_YELLOW    = 3'd1,
      ALLRED_TO_EW = 3'd2,
      EW_GREEN     = 3'd3,
      EW_YELLOW    = 3'd4,
      ALLRED_TO_NS = 3'd5
   } phase_t;

   localparam logic [2:0] LIGHT_R = 3'b100;
   localparam logic [2:0] LIGHT_Y = 3'b010;
   localparam logic [2:0] LIGHT_G = 3'b001;

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Sensor/button inputs and signal-head/countdown outputs of the scheduler.
interface intersection_phase_scheduler_if;

   logic       car_ns;
   logic       car_ew;
   logic       ped_ns_btn;
   logic       ped_ew_btn;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       ped_ns_walk;
   logic       ped_ew_walk;
   logic [2:0] phase;
   logic [5:0] time_left;
   logic       sec_tick;

   modport master (
      output car_ns, car_ew, ped_ns_btn, ped_ew_btn,
      input  ns_light, ew_light, ped_ns_walk, ped_ew_walk, phase, time_left, sec_tick
   );

   modport slave (
      input  car_ns, car_ew, ped_ns_btn, ped_ew_btn,
      output ns_light, ew_light, ped_ns_walk, ped_ew_walk, phase, time_left, sec_tick
   );

endinterface

// File: rtl/sec_tick_gen.sv
// Free-running prescaler producing a one-cycle pulse every CLK_FREQ cycles.
module sec_tick_gen #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic sec_tick
);

   localparam int unsigned CntW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_FREQ - 1);

   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d  = (count_q == CntMax) ? '0 : count_q + CntW'(1);
      sec_tick = (count_q == CntMax);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Actuated two-road phase sequencer with pedestrian latches and a seconds countdown.
module intersection_phase_scheduler #(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned GREEN_MIN   = 10,
   parameter int unsigned GREEN_MAX   = 30,
   parameter int unsigned YELLOW_TIME = 3,
   parameter int unsigned ALLRED_TIME = 2,
   parameter int unsigned PED_TIME    = 8
) (
   input logic                          clk,
   input logic                          rst,
   intersection_phase_scheduler_if.slave bus
);
   import traffic_pkg::*;

   localparam logic [6:0] GMin7  = 7'(GREEN_MIN);
   localparam logic [6:0] GMax7  = 7'(GREEN_MAX);
   localparam logic [6:0] PTime7 = 7'(PED_TIME);
   localparam logic [5:0] GMax6  = 6'(GREEN_MAX);
   localparam logic [5:0] YTime6 = 6'(YELLOW_TIME);
   localparam logic [5:0] ATime6 = 6'(ALLRED_TIME);

   logic       tick;
   phase_t     phase_q, phase_d;
   logic [5:0] elapsed_q, elapsed_d;
   logic [5:0] down_q, down_d;
   logic       ped_ns_req_q, ped_ns_req_d;
   logic       ped_ew_req_q, ped_ew_req_d;
   logic       walk_ns_q, walk_ns_d;
   logic       walk_ew_q, walk_ew_d;

   logic [6:0] el_p1;
   logic [5:0] el_sat;
   logic       opp_demand;
   logic       own_car;
   logic       green_exit;
   logic       down_last;
   logic [5:0] green_left;

   sec_tick_gen #(
      .CLK_FREQ(CLK_FREQ)
   ) u_sec_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .sec_tick(tick)
   );

   always_comb begin
      el_p1      = {1'b0, elapsed_q} + 7'd1;
      el_sat     = (elapsed_q == 6'd63) ? 6'd63 : elapsed_q + 6'd1;
      opp_demand = (phase_q == NS_GREEN) ? (bus.car_ew | ped_ew_req_q)
                                         : (bus.car_ns | ped_ns_req_q);
      own_car    = (phase_q == NS_GREEN) ? bus.car_ns : bus.car_ew;
      green_exit = tick && opp_demand && (el_p1 >= GMin7) && (!own_car || (el_p1 >= GMax7));
      down_last  = (down_q == 6'd1);
      green_left = (elapsed_q >= GMax6) ? 6'd0 : GMax6 - elapsed_q;
   end

   always_comb begin
      phase_d      = phase_q;
      elapsed_d    = elapsed_q;
      down_d       = down_q;
      walk_ns_d    = walk_ns_q;
      walk_ew_d    = walk_ew_q;
      // Presses during the approach's own walk interval are dropped.
      ped_ns_req_d = ped_ns_req_q | (bus.ped_ns_btn & ~walk_ns_q);
      ped_ew_req_d = ped_ew_req_q | (bus.ped_ew_btn & ~walk_ew_q);

      unique case (phase_q)
         NS_GREEN: begin
            if (tick) begin
               elapsed_d = el_sat;
               if (el_p1 == PTime7) walk_ns_d = 1'b0;
               if (green_exit) begin
                  phase_d   = NS_YELLOW;
                  down_d    = YTime6;
                  elapsed_d = '0;
                  walk_ns_d = 1'b0;
               end
            end
         end
         EW_GREEN: begin
            if (tick) begin
               elapsed_d = el_sat;
               if (el_p1 == PTime7) walk_ew_d = 1'b0;
               if (green_exit) begin
                  phase_d   = EW_YELLOW;
                  down_d    = YTime6;
                  elapsed_d = '0;
                  walk_ew_d = 1'b0;
               end
            end
         end
         NS_YELLOW, EW_YELLOW: begin
            if (tick) begin
               if (down_last) begin
                  phase_d = (phase_q == NS_YELLOW) ? ALLRED_TO_EW : ALLRED_TO_NS;
                  down_d  = ATime6;
               end else begin
                  down_d = down_q - 6'd1;
               end
            end
         end
         ALLRED_TO_EW: begin
            if (tick) begin
               if (down_last) begin
                  phase_d      = EW_GREEN;
                  down_d       = '0;
                  elapsed_d    = '0;
                  walk_ew_d    = ped_ew_req_q;
                  // A press landing on the entry edge survives for the next round.
                  ped_ew_req_d = bus.ped_ew_btn;
               end else begin
                  down_d = down_q - 6'd1;
               end
            end
         end
         ALLRED_TO_NS: begin
            if (tick) begin
               if (down_last) begin
                  phase_d      = NS_GREEN;
                  down_d       = '0;
                  elapsed_d    = '0;
                  walk_ns_d    = ped_ns_req_q;
                  ped_ns_req_d = bus.ped_ns_btn;
               end else begin
                  down_d = down_q - 6'd1;
               end
            end
         end
         default: begin
            phase_d   = NS_GREEN;
            elapsed_d = '0;
            down_d    = '0;
            walk_ns_d = 1'b0;
            walk_ew_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q      <= NS_GREEN;
         elapsed_q    <= '0;
         down_q       <= '0;
         ped_ns_req_q <= 1'b0;
         ped_ew_req_q <= 1'b0;
         walk_ns_q    <= 1'b0;
         walk_ew_q    <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         elapsed_q    <= elapsed_d;
         down_q       <= down_d;
         ped_ns_req_q <= ped_ns_req_d;
         ped_ew_req_q <= ped_ew_req_d;
         walk_ns_q    <= walk_ns_d;
         walk_ew_q    <= walk_ew_d;
      end
   end

   always_comb begin
      bus.ns_light  = LIGHT_R;
      bus.ew_light  = LIGHT_R;
      bus.time_left = down_q;
      unique case (phase_q)
         NS_GREEN: begin
            bus.ns_light  = LIGHT_G;
            bus.time_left = green_left;
         end
         EW_GREEN: begin
            bus.ew_light  = LIGHT_G;
            bus.time_left = green_left;
         end
         NS_YELLOW:    bus.ns_light = LIGHT_Y;
         EW_YELLOW:    bus.ew_light = LIGHT_Y;
         ALLRED_TO_EW: bus.ns_light = LIGHT_R;
         ALLRED_TO_NS: bus.ew_light = LIGHT_R;
         default:      bus.ns_light = LIGHT_R;
      endcase
      bus.phase       = phase_q;
      bus.ped_ns_walk = walk_ns_q;
      bus.ped_ew_walk = walk_ew_q;
      bus.sec_tick    = tick;
   end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for the phase scheduler with scaled-down timing (4 clocks per second).
module tb_intersection_phase_scheduler;
   import traffic_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total  = 0;
   int   passed = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   intersection_phase_scheduler_if bus ();

   intersection_phase_scheduler #(
      .CLK_FREQ   (4),
      .GREEN_MIN  (3),
      .GREEN_MAX  (6),
      .YELLOW_TIME(2),
      .ALLRED_TIME(1),
      .PED_TIME   (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [2:0] ns_of(input phase_t p);
      case (p)
         NS_GREEN:  return 3'b001;
         NS_YELLOW: return 3'b010;
         default:   return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] ew_of(input phase_t p);
      case (p)
         EW_GREEN:  return 3'b001;
         EW_YELLOW: return 3'b010;
         default:   return 3'b100;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input phase_t ph, input int tl);
      check({tag, "_phase"}, 32'(bus.phase), 32'(ph));
      check({tag, "_ns"}, 32'(bus.ns_light), 32'(ns_of(ph)));
      check({tag, "_ew"}, 32'(bus.ew_light), 32'(ew_of(ph)));
      check({tag, "_tl"}, 32'(bus.time_left), 32'(tl));
   endtask

   // Waits for a sec_tick cycle, optionally pulses ped_ns_btn in it, then steps past the edge.
   task automatic next_tick(input logic pulse_ns);
      bit seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.sec_tick === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("tick_seen", 32'(seen), 32'd1);
      if (pulse_ns) bus.ped_ns_btn = 1'b1;
      @(posedge clk);
      #1;
      bus.ped_ns_btn = 1'b0;
   endtask

   task automatic step(input string tag, input phase_t ph, input int tl);
      next_tick(1'b0);
      check_state(tag, ph, tl);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      phase_t ph;
      int     tl;
      int     o;

      bus.car_ns     = 1'b0;
      bus.car_ew     = 1'b0;
      bus.ped_ns_btn = 1'b0;
      bus.ped_ew_btn = 1'b0;

      // Idle from reset: NS rests, countdown runs out and holds at zero.
      #1;
      check_state("rst", NS_GREEN, 6);
      check("rst_tick", 32'(bus.sec_tick), 32'd0);
      check("rst_walks", 32'({bus.ped_ns_walk, bus.ped_ew_walk}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 30; k++) step("idle", NS_GREEN, (k < 6) ? 6 - k : 0);

      // EW car only: minimum green, yellow, all-red, then EW green.
      bus.car_ew = 1'b1;
      do_reset();
      step("ew1", NS_GREEN, 5);
      step("ew2", NS_GREEN, 4);
      step("ew3", NS_YELLOW, 2);
      step("ew4", NS_YELLOW, 1);
      step("ew5", ALLRED_TO_EW, 1);
      step("ew6", EW_GREEN, 6);
      bus.car_ew = 1'b0;
      bus.car_ns = 1'b1;
      step("ew7", EW_GREEN, 5);
      step("ew8", EW_GREEN, 4);
      step("ew9", EW_YELLOW, 2);

      // Asynchronous reset in the middle of EW yellow.
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_state("midrst", NS_GREEN, 6);
      check("midrst_walks", 32'({bus.ped_ns_walk, bus.ped_ew_walk}), 32'd0);
      check("midrst_tick", 32'(bus.sec_tick), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_state("postrst", NS_GREEN, 6);

      // Both approaches saturated: 6/2/1 alternation, never two greens.
      bus.car_ns = 1'b1;
      bus.car_ew = 1'b1;
      do_reset();
      for (int k = 1; k <= 36; k++) begin
         o = k % 18;
         if (o <= 5)       begin ph = NS_GREEN;     tl = 6 - o;  end
         else if (o <= 7)  begin ph = NS_YELLOW;    tl = 8 - o;  end
         else if (o == 8)  begin ph = ALLRED_TO_EW; tl = 1;      end
         else if (o <= 14) begin ph = EW_GREEN;     tl = 15 - o; end
         else if (o <= 16) begin ph = EW_YELLOW;    tl = 17 - o; end
         else              begin ph = ALLRED_TO_NS; tl = 1;      end
         next_tick(1'b0);
         check_state("busy", ph, tl);
         check("busy_dual_green", 32'(bus.ns_light[0] & bus.ew_light[0]), 32'd0);
      end

      // EW pedestrian pulse with no traffic.
      bus.car_ns = 1'b0;
      bus.car_ew = 1'b0;
      do_reset();
      step("ped1", NS_GREEN, 5);
      bus.ped_ew_btn = 1'b1;
      @(posedge clk);
      #1;
      bus.ped_ew_btn = 1'b0;
      step("ped2", NS_GREEN, 4);
      step("ped3", NS_YELLOW, 2);
      step("ped4", NS_YELLOW, 1);
      step("ped5", ALLRED_TO_EW, 1);
      step("ped6", EW_GREEN, 6);
      check("ped6_walk", 32'(bus.ped_ew_walk), 32'd1);
      step("ped7", EW_GREEN, 5);
      check("ped7_walk", 32'(bus.ped_ew_walk), 32'd1);
      step("ped8", EW_GREEN, 4);
      check("ped8_walk", 32'(bus.ped_ew_walk), 32'd0);
      for (int k = 9; k <= 14; k++) step("ped_rest", EW_GREEN, (k < 12) ? 12 - k : 0);
      bus.car_ns = 1'b1;
      step("ped15", EW_YELLOW, 2);
      bus.car_ns = 1'b0;
      step("ped16", EW_YELLOW, 1);
      step("ped17", ALLRED_TO_NS, 1);
      step("ped18", NS_GREEN, 6);
      check("ped18_walk", 32'(bus.ped_ns_walk), 32'd0);
      // Cleared EW latch leaves NS resting past minimum green.
      for (int k = 19; k <= 24; k++) step("ped_nsrest", NS_GREEN, 24 - k);

      // NS press on the edge that enters NS green is carried to the next NS green.
      bus.car_ew = 1'b1;
      do_reset();
      for (int k = 1; k <= 5; k++) next_tick(1'b0);
      step("edge6", EW_GREEN, 6);
      bus.car_ew = 1'b0;
      bus.car_ns = 1'b1;
      step("edge7", EW_GREEN, 5);
      step("edge8", EW_GREEN, 4);
      step("edge9", EW_YELLOW, 2);
      step("edge10", EW_YELLOW, 1);
      step("edge11", ALLRED_TO_NS, 1);
      next_tick(1'b1);
      check_state("edge12", NS_GREEN, 6);
      check("edge12_walk", 32'(bus.ped_ns_walk), 32'd0);
      bus.car_ns = 1'b0;
      bus.car_ew = 1'b1;
      step("edge13", NS_GREEN, 5);
      check("edge13_walk", 32'(bus.ped_ns_walk), 32'd0);
      step("edge14", NS_GREEN, 4);
      step("edge15", NS_YELLOW, 2);
      step("edge16", NS_YELLOW, 1);
      step("edge17", ALLRED_TO_EW, 1);
      step("edge18", EW_GREEN, 6);
      bus.car_ew = 1'b0;
      step("edge19", EW_GREEN, 5);
      step("edge20", EW_GREEN, 4);
      step("edge21", EW_YELLOW, 2);
      step("edge22", EW_YELLOW, 1);
      step("edge23", ALLRED_TO_NS, 1);
      step("edge24", NS_GREEN, 6);
      check("edge24_walk", 32'(bus.ped_ns_walk), 32'd1);
      step("edge25", NS_GREEN, 5);
      check("edge25_walk", 32'(bus.ped_ns_walk), 32'd1);
      step("edge26", NS_GREEN, 4);
      check("edge26_walk", 32'(bus.ped_ns_walk), 32'd0);
      step("edge27", NS_GREEN, 3);
      step("edge28", NS_GREEN, 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
